cpu7_dmem_resp: RTL and testbench

CPU7_DMEM_RESP -- requirements
Module: cpu7_dmem_resp

---
 rtl/cpu7_dmem_resp.sv | 149 ++++++++++++++
 tb/tb_cpu7_dmem_resp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu7_dmem_resp.sv
// Data-memory responder for the cpu7 core: up to two outstanding requests are
// answered in order after a fixed latency, with range checking and LL/SC support.
module cpu7_dmem_resp #(
  parameter int AW  = 10,
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  input  logic        data_ll,
  input  logic        data_sc,
  input  logic        data_prefetch,
  input  logic        data_recv,
  input  logic        data_cancel,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        data_scsucceed,
  output logic        data_exception,
  output logic [5:0]  data_excode,
  output logic [31:0] data_badvaddr,
  output logic        data_req_empty
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT      = 2'd1;
  localparam logic [1:0] RESP      = 2'd2;
  localparam logic [1:0] WAIT_LOAD = (LAT > 1) ? 2'(LAT - 2) : 2'd0;
  localparam logic [5:0] EXC_ADE   = 6'h08;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [31:0]   q_rdata [0:1];
  logic          q_sc    [0:1];
  logic          q_exc   [0:1];
  logic [5:0]    q_code  [0:1];
  logic [31:0]   q_badv  [0:1];

  logic          rd_ptr, wr_ptr, run_q;
  logic [1:0]    count, state, lat_cnt;
  logic          llbit;
  logic [AW-1:0] lladdr;

  logic [AW-1:0] word_idx;
  logic          bad_addr, accept, retire, valid_op;
  logic          is_load, is_store, is_sc, sc_ok, do_write, more_left;
  logic [31:0]   new_rdata;

  // run_q keeps the request port closed while reset is asserted without
  // routing the asynchronous reset into any synchronous data path.
  assign data_addr_ok   = run_q & data_req & ~count[1] & ~data_cancel;
  assign data_req_empty = (count == 2'd0);

  always_comb begin
    word_idx  = data_addr[AW+1:2];
    bad_addr  = ((data_addr >> (AW + 2)) != 32'd0) || (data_addr[1:0] != 2'b00);
    accept    = data_addr_ok;
    retire    = (state == RESP) & data_recv & ~data_cancel;
    valid_op  = accept & ~bad_addr & ~data_prefetch;
    is_load   = valid_op & ~data_wr;
    is_store  = valid_op & data_wr & ~data_sc;
    is_sc     = valid_op & data_wr & data_sc;
    sc_ok     = is_sc & llbit & (lladdr == word_idx);
    do_write  = is_store | sc_ok;
    more_left = count[1] | accept;
    new_rdata = is_load ? mem[word_idx] : 32'd0;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (do_write && data_wstrb[b]) begin
        mem[word_idx][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
    if (accept) begin
      q_rdata[wr_ptr] <= new_rdata;
      q_sc[wr_ptr]    <= sc_ok;
      q_exc[wr_ptr]   <= bad_addr;
      q_code[wr_ptr]  <= bad_addr ? EXC_ADE : 6'd0;
      q_badv[wr_ptr]  <= bad_addr ? data_addr : 32'd0;
    end
  end

  // Cancel flushes the queue and head FSM but leaves the LL reservation alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q   <= 1'b0;
      count   <= 2'd0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      state   <= IDLE;
      lat_cnt <= 2'd0;
      llbit   <= 1'b0;
      lladdr  <= '0;
    end else begin
      run_q <= 1'b1;
      if (is_load && data_ll) begin
        llbit  <= 1'b1;
        lladdr <= word_idx;
      end else if (is_sc || (is_store && (word_idx == lladdr))) begin
        llbit <= 1'b0;
      end
      if (data_cancel) begin
        count   <= 2'd0;
        rd_ptr  <= 1'b0;
        wr_ptr  <= 1'b0;
        state   <= IDLE;
        lat_cnt <= 2'd0;
      end else begin
        if (accept) wr_ptr <= ~wr_ptr;
        if (retire) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, accept} - {1'b0, retire};
        case (state)
          IDLE: begin
            if (accept) begin
              state   <= (LAT == 1) ? RESP : WAIT;
              lat_cnt <= WAIT_LOAD;
            end
          end
          WAIT: begin
            if (lat_cnt == 2'd0) state <= RESP;
            else lat_cnt <= lat_cnt - 2'd1;
          end
          RESP: begin
            if (retire) begin
              if (more_left) begin
                state   <= (LAT == 1) ? RESP : WAIT;
                lat_cnt <= WAIT_LOAD;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign data_data_ok   = (state == RESP) & ~data_cancel;
  assign data_rdata     = data_data_ok ? q_rdata[rd_ptr] : 32'd0;
  assign data_scsucceed = data_data_ok & q_sc[rd_ptr];
  assign data_exception = data_data_ok & q_exc[rd_ptr];
  assign data_excode    = data_data_ok ? q_code[rd_ptr] : 6'd0;
  assign data_badvaddr  = data_data_ok ? q_badv[rd_ptr] : 32'd0;

endmodule

// File: tb/tb_cpu7_dmem_resp.sv
// Bench for cpu7_dmem_resp: directed scenarios then random traffic, all checked
// against a transaction-level model (word array, LL state, queue of responses).
module tb_cpu7_dmem_resp;
  localparam int AW  = 10;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_req, data_wr, data_ll, data_sc, data_prefetch, data_recv, data_cancel;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok, data_scsucceed, data_exception, data_req_empty;
  logic [31:0] data_rdata, data_badvaddr;
  logic [5:0]  data_excode;

  cpu7_dmem_resp #(.AW(AW), .LAT(LAT)) dut (
    .clk(clk), .resetn(resetn), .data_req(data_req), .data_addr(data_addr),
    .data_wr(data_wr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_ll(data_ll), .data_sc(data_sc), .data_prefetch(data_prefetch),
    .data_recv(data_recv), .data_cancel(data_cancel), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .data_scsucceed(data_scsucceed),
    .data_exception(data_exception), .data_excode(data_excode),
    .data_badvaddr(data_badvaddr), .data_req_empty(data_req_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        sc;
    logic        exc;
    logic [5:0]  code;
    logic [31:0] badv;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] mmem [0:(1<<AW)-1];
  logic        m_llbit;
  int          m_lladdr;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [71:0] pack(input resp_t r);
    return {r.rdata, r.sc, r.exc, r.code, r.badv};
  endfunction

  function automatic logic [71:0] resp_bus();
    return {data_rdata, data_scsucceed, data_exception, data_excode, data_badvaddr};
  endfunction

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one accepted request, at the level of whole words.
  task automatic model_accept(input logic wr, input logic [31:0] addr, input logic [3:0] wstrb,
                              input logic [31:0] wdata, input logic ll, input logic sc,
                              input logic pf);
    resp_t       r;
    int          idx;
    logic [31:0] w;
    r = '{rdata: 32'd0, sc: 1'b0, exc: 1'b0, code: 6'd0, badv: 32'd0};
    idx = int'(addr / 4);
    if (addr >= 32'(1 << (AW + 2)) || (addr % 4) != 0) begin
      r.exc  = 1'b1;
      r.code = 6'h08;
      r.badv = addr;
    end else if (pf) begin
      r.rdata = 32'd0;
    end else if (wr) begin
      if (!sc || (m_llbit && m_lladdr == idx)) begin
        w = mmem[idx];
        for (int b = 0; b < 4; b++) if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
        mmem[idx] = w;
        r.sc = sc;
      end
      if (sc || m_lladdr == idx) m_llbit = 1'b0;
    end else begin
      r.rdata = mmem[idx];
      if (ll) begin
        m_llbit  = 1'b1;
        m_lladdr = idx;
      end
    end
    exp_q.push_back(r);
  endtask

  // One clock cycle: drive just after a rising edge, check on the falling edge.
  task automatic applyStimulus(input logic req, input logic wr, input logic [31:0] addr,
                               input logic [3:0] wstrb, input logic [31:0] wdata,
                               input logic ll, input logic sc, input logic pf,
                               input logic recv, input logic cancel, input string tag);
    int          sz;
    logic        exp_aok, exp_dok;
    logic [71:0] exp_resp;
    sz       = exp_q.size();
    exp_aok  = req && sz < 2 && !cancel;
    exp_dok  = sz > 0 && !cancel;
    exp_resp = exp_dok ? pack(exp_q[0]) : 72'd0;
    data_req = req; data_wr = wr; data_addr = addr; data_wstrb = wstrb; data_wdata = wdata;
    data_ll = ll; data_sc = sc; data_prefetch = pf; data_recv = recv; data_cancel = cancel;
    @(negedge clk);
    checkOutput({tag, ".addr_ok"}, 72'(data_addr_ok), 72'(exp_aok));
    checkOutput({tag, ".data_ok"}, 72'(data_data_ok), 72'(exp_dok));
    checkOutput({tag, ".req_empty"}, 72'(data_req_empty), 72'(sz == 0));
    checkOutput({tag, ".resp"}, resp_bus(), exp_resp);
    if (cancel) begin
      exp_q.delete();
    end else begin
      if (recv && exp_dok) void'(exp_q.pop_front());
      if (exp_aok) model_accept(wr, addr, wstrb, wdata, ll, sc, pf);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic recv, input string tag);
    applyStimulus(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, recv, 1'b0, tag);
  endtask

  task automatic load(input logic [31:0] addr, input logic ll, input logic recv, input string tag);
    applyStimulus(1'b1, 1'b0, addr, 4'd0, 32'd0, ll, 1'b0, 1'b0, recv, 1'b0, tag);
  endtask

  task automatic store(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                       input logic sc, input logic recv, input string tag);
    applyStimulus(1'b1, 1'b1, addr, wstrb, wdata, 1'b0, sc, 1'b0, recv, 1'b0, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, ".addr_ok"}, 72'(data_addr_ok), 72'd0);
    checkOutput({tag, ".data_ok"}, 72'(data_data_ok), 72'd0);
    checkOutput({tag, ".resp"}, resp_bus(), 72'd0);
    checkOutput({tag, ".req_empty"}, 72'(data_req_empty), 72'd1);
  endtask

  logic [31:0] ra;
  int          k;
  logic        rwr, rpf, rll, rsc;

  initial begin
    resetn = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_addr = 32'd0; data_wstrb = 4'd0;
    data_wdata = 32'd0; data_ll = 1'b0; data_sc = 1'b0; data_prefetch = 1'b0;
    data_recv = 1'b0; data_cancel = 1'b0;
    m_llbit = 1'b0; m_lladdr = 0;
    #3;
    check_reset_outputs("reset0");
    @(posedge clk); #1 resetn = 1'b1; data_req = 1'b0;
    @(posedge clk); #1;

    // Give the first 16 words known contents; each store retires the previous one.
    for (int w = 0; w < 16; w++) store(32'(w * 4), 4'hF, $urandom, 1'b0, 1'b1, "init");
    idle(1'b1, "init_drain");

    store(32'h10, 4'hF, 32'h1234_5678, 1'b0, 1'b1, "st10");
    load(32'h10, 1'b0, 1'b1, "ld10");
    #2 checkOutput("ld10.latency", 72'(data_data_ok), 72'd1);
    checkOutput("ld10.rdata", 72'(data_rdata), 72'h1234_5678);
    store(32'h10, 4'b0010, 32'h0000_AB00, 1'b0, 1'b1, "st10_part");
    load(32'h10, 1'b0, 1'b1, "ld10_part");
    #2 checkOutput("ld10_part.rdata", 72'(data_rdata), 72'h1234_AB78);

    load(32'h20, 1'b1, 1'b1, "ll20");
    store(32'h20, 4'hF, 32'hCAFE_F00D, 1'b1, 1'b1, "sc20_ok");
    #2 checkOutput("sc20_ok.scsucceed", 72'(data_scsucceed), 72'd1);
    load(32'h20, 1'b0, 1'b1, "ld20_a");
    #2 checkOutput("ld20_a.rdata", 72'(data_rdata), 72'hCAFE_F00D);
    load(32'h20, 1'b1, 1'b1, "ll20_b");
    store(32'h20, 4'hF, 32'h1111_1111, 1'b0, 1'b1, "st20_mid");
    store(32'h20, 4'hF, 32'h2222_2222, 1'b1, 1'b1, "sc20_fail");
    #2 checkOutput("sc20_fail.scsucceed", 72'(data_scsucceed), 72'd0);
    load(32'h20, 1'b0, 1'b1, "ld20_b");
    #2 checkOutput("ld20_b.rdata", 72'(data_rdata), 72'h1111_1111);
    idle(1'b1, "drain1");

    load(32'h04, 1'b0, 1'b0, "bp1");
    load(32'h08, 1'b0, 1'b0, "bp2");
    load(32'h0C, 1'b0, 1'b0, "bp3");
    #2 checkOutput("bp3.addr_ok", 72'(data_addr_ok), 72'd0);
    idle(1'b1, "bp_drain1");
    idle(1'b1, "bp_drain2");
    idle(1'b1, "bp_drain3");

    load(32'h1000, 1'b0, 1'b1, "exc_range");
    #2 checkOutput("exc_range.fields", {40'd0, data_exception, data_excode, data_badvaddr},
                   {40'd0, 1'b1, 6'h08, 32'h0000_1000});
    load(32'h12, 1'b0, 1'b1, "exc_align");
    #2 checkOutput("exc_align.fields", {40'd0, data_exception, data_excode, data_badvaddr},
                   {40'd0, 1'b1, 6'h08, 32'h0000_0012});
    idle(1'b1, "drain2");

    load(32'h00, 1'b0, 1'b0, "cn1");
    load(32'h04, 1'b0, 1'b0, "cn2");
    applyStimulus(1'b1, 1'b0, 32'h08, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "cancel");
    idle(1'b0, "post_cancel");
    idle(1'b1, "post_cancel2");

    store(32'h30, 4'hF, 32'hA5A5_5A5A, 1'b0, 1'b1, "st30");
    load(32'h30, 1'b1, 1'b0, "ll30");
    #2 resetn = 1'b0;
    #1 check_reset_outputs("reset_mid");
    exp_q.delete();
    m_llbit = 1'b0; m_lladdr = 0;
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
    store(32'h30, 4'hF, 32'h0BAD_0BAD, 1'b1, 1'b1, "sc30_after_reset");
    load(32'h30, 1'b0, 1'b1, "ld30");
    #2 checkOutput("ld30.persist", 72'(data_rdata), 72'hA5A5_5A5A);
    idle(1'b1, "drain3");

    for (int i = 0; i < 400; i++) begin
      k  = $urandom_range(0, 19);
      ra = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if (k == 0) ra = 32'h1000 + ($urandom & 32'h0000_0FFC);
      else if (k == 1) ra = ra | 32'($urandom_range(1, 3));
      rwr = ($urandom_range(0, 2) == 0);
      rpf = !rwr && ($urandom_range(0, 9) == 0);
      rll = !rwr && !rpf && ($urandom_range(0, 3) == 0);
      rsc = rwr && ($urandom_range(0, 2) == 0);
      applyStimulus($urandom_range(0, 3) != 0, rwr, ra, 4'($urandom), $urandom, rll, rsc, rpf,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
